// File: rtl/xor32_descrambler.sv
// xor32_descrambler
//   Word-serial XOR keystream descrambler for 32-bit frames. A Galois LFSR
//   is seeded per frame and advanced once per accepted word; each accepted
//   word is XORed with the current keystream word into a single output
//   register (1-cycle latency, full throughput with valid/ready on both sides).
//
// Parameters
//   POLY       Galois feedback taps
//   FRAME_LEN  words per frame (1..65535)
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   seed_valid/seed  seed load, honoured only while idle (zero seed -> all ones)
//   in_valid/in_ready/in_data     scrambled word input handshake
//   out_valid/out_ready/out_data  descrambled word output handshake
//   busy             high while a frame is in progress
//   frame_done       one-cycle pulse after the last word of a frame is accepted
//
// Optional feature (macro XOR32_DESCR_PARITY_EN)
//   in_par   even parity of the scrambled word
//   out_perr parity error flag travelling with out_data
module xor32_descrambler #(
    parameter logic [31:0] POLY      = 32'h04C11DB7,
    parameter int unsigned FRAME_LEN = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_valid,
    input  logic [31:0] seed,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        frame_done
`ifdef XOR32_DESCR_PARITY_EN
    ,
    input  logic        in_par,
    output logic        out_perr
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_key;
    logic [15:0] r_cnt;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic        r_frame_done;

    logic        w_accept;
    logic        w_last;
    logic [31:0] w_key_next;

    // Input readiness depends only on state and the output slot, never on in_valid.
    assign in_ready   = (r_state == S_RUN) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_last     = (r_cnt == 16'(FRAME_LEN - 1));
    assign w_key_next = {r_key[30:0], 1'b0} ^ (r_key[31] ? POLY : '0);

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign busy       = (r_state == S_RUN);
    assign frame_done = r_frame_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_key        <= '0;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (seed_valid) begin
                        // An all-zero seed would lock the LFSR at zero.
                        r_key   <= (seed == '0) ? '1 : seed;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_key <= w_key_next;
                        r_cnt <= r_cnt + 16'd1;
                        if (w_last) begin
                            r_state      <= S_IDLE;
                            r_frame_done <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Output slot: reload on accept (also when draining the same cycle),
            // otherwise empty it once consumed. Data is held when not reloaded.
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= in_data ^ r_key;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef XOR32_DESCR_PARITY_EN
    logic r_out_perr;

    assign out_perr = r_out_perr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_perr <= 1'b0;
        end else if (w_accept) begin
            r_out_perr <= (^in_data) ^ in_par;
        end
    end
`endif

endmodule

// File: tb/tb_xor32_descrambler.sv
module tb_xor32_descrambler;

    localparam logic [31:0] POLY      = 32'h04C11DB7;
    localparam int          FRAME_LEN = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_valid = 1'b0;
    logic [31:0] seed = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        busy;
    logic        frame_done;
`ifdef XOR32_DESCR_PARITY_EN
    logic        in_par = 1'b0;
    logic        out_perr;
`endif

    xor32_descrambler #(.POLY(POLY), .FRAME_LEN(FRAME_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_valid (seed_valid),
        .seed       (seed),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef XOR32_DESCR_PARITY_EN
        ,
        .in_par     (in_par),
        .out_perr   (out_perr)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Keystream word k of a frame: k Galois steps applied to the effective seed.
    function automatic logic [31:0] key_at(input logic [31:0] s, input int k);
        logic [31:0] v;
        v = s;
        for (int i = 0; i < k; i++)
            v = (v << 1) ^ (v[31] ? POLY : 32'h0);
        return v;
    endfunction

    // Transaction-level reference: frame in progress, word index, pending output.
    bit          m_run = 0;
    int          m_idx = 0;
    logic [31:0] m_seed = '0;
    bit          m_pv = 0;
    logic [31:0] m_od = '0;
    bit          m_fd = 0;
    bit          m_pe = 0;
    bit          m_acc = 0;

    always @(posedge clk) begin
        bit run0;
        bit acc;
        run0 = m_run;
        acc  = run0 && (!m_pv || out_ready) && in_valid;
        if (rst) begin
            m_run = 0; m_idx = 0; m_pv = 0; m_od = '0; m_fd = 0; m_pe = 0; m_acc = 0;
        end else begin
            m_acc = acc;
            m_fd  = 0;
            if (!run0 && seed_valid) begin
                m_run  = 1;
                m_idx  = 0;
                m_seed = (seed == 32'h0) ? 32'hFFFFFFFF : seed;
            end
            if (acc) begin
                m_od = in_data ^ key_at(m_seed, m_idx);
`ifdef XOR32_DESCR_PARITY_EN
                m_pe = (^in_data) ^ in_par;
`endif
                m_pv = 1;
                m_idx++;
                if (m_idx == FRAME_LEN) begin
                    m_run = 0;
                    m_fd  = 1;
                end
            end else if (m_pv && out_ready) begin
                m_pv = 0;
            end
        end
    end

    // Per-cycle comparison and capture of consumed output words.
    bit          chk_en = 0;
    logic [31:0] got[$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",   {31'h0, in_ready},   {31'h0, m_run && (!m_pv || out_ready)});
            chk("out_valid",  {31'h0, out_valid},  {31'h0, m_pv});
            chk("out_data",   out_data,            m_od);
            chk("busy",       {31'h0, busy},       {31'h0, m_run});
            chk("frame_done", {31'h0, frame_done}, {31'h0, m_fd});
`ifdef XOR32_DESCR_PARITY_EN
            chk("out_perr",   {31'h0, out_perr},   {31'h0, m_pe});
`endif
            if (out_valid === 1'b1 && out_ready === 1'b1)
                got.push_back(out_data);
        end
    end

    logic [31:0] words[$];
    int          bad_par_idx = -1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        seed_valid = 1'b0;
        in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
    endtask

    // mode 0: always ready; 1: random valid/ready plus stray seeds in RUN;
    // 2: out_ready held low for 4 cycles after the first accept.
    task automatic send_frame(input logic [31:0] s, input int n, input int mode);
        int idx = 0;
        int c = 0;
        int budget = 400;
        seed = s;
        seed_valid = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        seed_valid = 1'b0;
        while (idx < n && budget > 0) begin
            in_data = words[idx];
`ifdef XOR32_DESCR_PARITY_EN
            in_par = (^words[idx]) ^ (idx == bad_par_idx);
`endif
            case (mode)
                1: begin
                    in_valid   = ($urandom_range(0, 3) != 0);
                    out_ready  = ($urandom_range(0, 2) != 0);
                    seed_valid = ($urandom_range(0, 7) == 0);
                    seed       = $urandom;
                end
                2: begin
                    in_valid  = 1'b1;
                    out_ready = !(c >= 1 && c <= 4);
                end
                default: begin
                    in_valid  = 1'b1;
                    out_ready = 1'b1;
                end
            endcase
            tick();
            if (m_acc) idx++;
            c++;
            budget--;
        end
        seed_valid = 1'b0;
        in_valid   = 1'b0;
        if (budget == 0) begin
            bad++;
            $display("FAIL frame_timeout: got %0d words accepted expected %0d", idx, n);
        end
    endtask

    initial begin
        do_reset();
        chk_en = 1;
        repeat (5) tick();

        // seed 1: keys 1, 2
        words.delete();
        words.push_back(32'hDEADBEEF);
        words.push_back(32'h00000002);
        for (int i = 2; i < FRAME_LEN; i++) words.push_back($urandom);
        got.delete();
        send_frame(32'h00000001, FRAME_LEN, 0);
        drain();
        chk("n_out_seed1", got.size(), FRAME_LEN);
        chk("lit_w0_seed1", got[0], 32'hDEADBEEE);
        chk("lit_w1_seed1", got[1], 32'h00000000);

        // seed with MSB set exercises the feedback taps
        words.delete();
        for (int i = 0; i < FRAME_LEN; i++) words.push_back(32'h0);
        got.delete();
        send_frame(32'h80000000, FRAME_LEN, 0);
        drain();
        chk("lit_w0_msb", got[0], 32'h80000000);
        chk("lit_w1_msb", got[1], 32'h04C11DB7);

        // zero seed is replaced by all ones
        got.delete();
        send_frame(32'h00000000, FRAME_LEN, 0);
        drain();
        chk("lit_w0_zero", got[0], 32'hFFFFFFFF);

        // backpressure: nothing lost or duplicated
        words.delete();
        for (int i = 0; i < FRAME_LEN; i++) words.push_back($urandom);
        got.delete();
        send_frame(32'h00000001, FRAME_LEN, 2);
        drain();
        chk("n_out_hold", got.size(), FRAME_LEN);
        chk("lit_w0_hold", got[0], words[0] ^ 32'h00000001);
        chk("lit_w1_hold", got[1], words[1] ^ 32'h00000002);

        // randomized frames, some back-to-back with a pending output
        for (int f = 0; f < 8; f++) begin
            logic [31:0] s;
            words.delete();
            for (int i = 0; i < FRAME_LEN; i++) words.push_back($urandom);
            s = (f == 3) ? 32'h0 : $urandom;
            send_frame(s, FRAME_LEN, 1);
            if (f % 2 == 1) drain();
        end
        drain();

        // reset after 3 words with an output pending, then a fresh seed
        words.delete();
        for (int i = 0; i < FRAME_LEN; i++) words.push_back($urandom);
        send_frame(32'h12345678, 3, 0);
        out_ready = 1'b0;
        tick();
        do_reset();
        out_ready = 1'b1;
        tick();
        words.delete();
        for (int i = 0; i < FRAME_LEN; i++) words.push_back(32'h0);
        bad_par_idx = 2;
        got.delete();
        send_frame(32'h00000001, FRAME_LEN, 0);
        drain();
        bad_par_idx = -1;
        chk("n_out_after_rst", got.size(), FRAME_LEN);
        chk("lit_w0_after_rst", got[0], 32'h00000001);
        chk("lit_w2_after_rst", got[2], 32'h00000004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/xor32_descrambler.md
# xor32_descrambler

Word-serial XOR keystream descrambler for 32-bit data frames. It is the receive-side counterpart of the datapath's XOR scrambler: it regenerates the same LFSR keystream from a shared seed and XORs it back out of each incoming word. It sits between the scrambled-word source and the consumer, with valid/ready handshakes on both sides and a 1-cycle registered datapath.

## Interface
- `POLY`, default 32'h04C11DB7: Galois LFSR feedback taps.
- `FRAME_LEN`, default 16: number of words per frame, from 1 to 65535.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `seed_valid` in 1: loads `seed` and starts a frame. Honoured only in IDLE.
- `seed` in 32: initial keystream word.
- `in_valid` in 1: scrambled word present.
- `in_ready` out 1: descrambler accepts the input word this cycle.
- `in_data` in 32: scrambled word.
- `out_valid` out 1: descrambled word present.
- `out_ready` in 1: consumer accepts the output word.
- `out_data` out 32: descrambled word.
- `busy` out 1: high in RUN.
- `frame_done` out 1: one-cycle pulse when the last word of a frame is accepted.

## Operation
- FSM has two states, IDLE and RUN.
- IDLE → RUN on `seed_valid`.
  - `key` ← `seed`. If `seed` is 0, `key` ← 32'hFFFFFFFF instead, to avoid LFSR lock-up.
  - `cnt` ← 0.
- RUN → IDLE when the input word with `cnt` == `FRAME_LEN`-1 is accepted. `frame_done` pulses on that same edge.
- `seed_valid` is ignored in RUN.
- `in_ready` = (state==RUN) && (!`out_valid` || `out_ready`). `in_ready` is combinational and must not depend on `in_valid`.
- Input accept = `in_valid` && `in_ready`. On accept:
  - `out_data` ← `in_data` ^ `key`
  - `out_valid` ← 1
  - `cnt` ← `cnt`+1
  - `key` ← {`key`[30:0],1'b0} ^ (`key`[31] ? `POLY` : 0). This is one Galois step per accepted word.
- `key` and `cnt` do not change when no input is accepted.
- If `out_valid` && `out_ready` and there is no accept in the same cycle, `out_valid` ← 0.
- Output hold rule: while `out_valid` && !`out_ready`, `out_data` is stable.
- Simultaneous output accept and input accept: the output register reloads with the new word and `out_valid` stays 1. This gives full throughput of one word per cycle.
- Frame end: a pending output word can drain while the FSM is in IDLE. A new `seed_valid` in IDLE is legal while `out_valid` is still high. The output register is unaffected by the seed load.
- `cnt` is 16 bits wide and is cleared on each seed load. It never wraps within a frame.

## Timing
- Reset values:
  - state = IDLE
  - `key` = 0
  - `cnt` = 0
  - `out_valid` = 0
  - `out_data` = 0
  - `frame_done` = 0
  - `busy` = 0
  - `in_ready` = 0
- Reset mid-frame: the partial frame is discarded, including any pending output word, on the next edge.
- Latency: an input accepted at edge N appears at `out_data`/`out_valid` after edge N.
- Seed to first accept: `seed_valid` sampled at edge N gives `in_ready` high during cycle N+1. The earliest accept is therefore at edge N+1.
- `frame_done` is high for exactly the one cycle following the last-word accept edge.
- `busy` is high from the edge after the seed load through the last-word accept edge. It is low in the cycle `frame_done` is high.

## Configuration
- `XOR32_DESCR_PARITY_EN` defined:
  - Adds input `in_par` (1 bit), the even parity of the scrambled word.
  - Adds output `out_perr` (1 bit, reset 0). It is loaded on each accept with ^`in_data` ^ `in_par`, and held and cleared with the same rules as `out_data`.
  - No effect on the handshake.
- `XOR32_DESCR_PARITY_EN` undefined: both ports are absent and there is no parity logic.

## Test plan
- Reset, then idle for 5 cycles → `in_ready`=0, `out_valid`=0, `busy`=0, all outputs 0.
- `seed`=32'h00000001, `FRAME_LEN`=2, `out_ready`=1. Send 32'hDEADBEEF then 32'h00000002 back-to-back → outputs are 32'hDEADBEEE then 32'h00000000 on consecutive cycles. `frame_done` pulses once, and the FSM returns to IDLE.
- `seed`=32'h80000000, send 32'h0, 32'h0 → outputs 32'h80000000, 32'h04C11DB7, confirming the feedback step.
- `seed`=0, send 32'h0 → output 32'hFFFFFFFF.
- Hold `out_ready`=0 for 4 cycles with `in_valid`=1 → `in_ready`=0 after the first accept, and `out_data` stays stable. Release `out_ready` → no word is lost or duplicated and the key sequence continues.
- Assert `rst` after 3 of 16 words, then seed again → the first output uses the new seed's key. With `XOR32_DESCR_PARITY_EN`, `in_par` wrong on word 2 → `out_perr`=1 on that word only.
